// File: rtl/pat_link_pkg.sv
// Shared definitions for the pad-level iMem link (loader and readback
// transmitter). This is the single definition of the frame format:
// {pad, address, data}, sent MS byte first.
// Contents: widths, frame geometry, FSM state encoding, frame helpers.
package pat_link_pkg;

  localparam int ADDR_W      = 10;
  localparam int DATA_W      = 40;
  localparam int FRAME_BYTES = (ADDR_W + DATA_W + 7) / 8;
  localparam int FRAME_W     = FRAME_BYTES * 8;
  localparam int PAD_W       = FRAME_W - ADDR_W - DATA_W;
  localparam int IDX_W       = $clog2(FRAME_BYTES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    LATCH   = 3'd2,
    SETUP   = 3'd3,
    STROBE  = 3'd4,
    RELEASE = 3'd5
  } link_state_e;

  function automatic logic [FRAME_W-1:0] pack_frame(input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    return {{PAD_W{1'b0}}, addr, data};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] frame,
                                            input logic [IDX_W-1:0]   idx);
    return frame[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/imem_readback_tx_if.sv
// Bus bundle for the readback transmitter: core request side, iMem read
// port and the io_b pad link.
//   master : the transmitter's view (drives req_ready, imem_rd_*, out_*,
//            busy, done)
//   slave  : the environment's view (core, iMem, host pad)
interface imem_readback_tx_if;
  import pat_link_pkg::*;

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              abort;
  logic              imem_rd_en;
  logic [ADDR_W-1:0] imem_rd_adr;
  logic [DATA_W-1:0] imem_rd_data;
  logic [7:0]        out_byte;
  logic              out_strobe;
  logic              host_ack;
  logic              busy;
  logic              done;

  modport master (
    input  req_valid, req_addr, abort, imem_rd_data, host_ack,
    output req_ready, imem_rd_en, imem_rd_adr, out_byte, out_strobe, busy, done
  );

  modport slave (
    output req_valid, req_addr, abort, imem_rd_data, host_ack,
    input  req_ready, imem_rd_en, imem_rd_adr, out_byte, out_strobe, busy, done
  );

endinterface

// File: rtl/link_sync2.sv
// Two-flop synchroniser for a single asynchronous level (host ack, loader
// strobe/write). Both flops clear on reset.
//   clk, rst_n : destination clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronised output
module link_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/imem_readback_tx.sv
// iMem readback transmitter. On an accepted request it reads one iMem word,
// packs {pad, addr, data} into a FRAME_BYTES frame and sends it MS byte
// first over a 4-phase strobe/ack handshake on the io_b pins.
//   clk_int, reset_n : core clock, async active-low reset
//   bus (master)     : request, abort, iMem read port, out_byte/out_strobe,
//                      host_ack, busy, done
// SETUP_CYCLES: cycles out_byte is stable before out_strobe rises.
module imem_readback_tx
  import pat_link_pkg::*;
#(
  parameter int SETUP_CYCLES = 2
) (
  input  logic clk_int,
  input  logic reset_n,
  imem_readback_tx_if.master bus
);

  localparam int CNT_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES + 1) : 1;
  // The LATCH cycle already presents the first byte, so it counts as one
  // setup cycle for byte 6; SETUP itself is always at least one cycle.
  localparam int FIRST_WAIT = (SETUP_CYCLES > 1) ? SETUP_CYCLES - 2 : 0;
  localparam int NEXT_WAIT  = (SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0;

  link_state_e        state, nxt;
  logic [ADDR_W-1:0]  addr_q;
  logic [FRAME_W-1:0] frame_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ack_s;
  logic               accept;

  link_sync2 u_ack_sync (
    .clk   (clk_int),
    .rst_n (reset_n),
    .d     (bus.host_ack),
    .q     (ack_s)
  );

  // abort wins over a same-cycle request
  assign accept = (state == IDLE) && bus.req_valid && !bus.abort;

  always_ff @(posedge clk_int or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      frame_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE:    if (accept) addr_q <= bus.req_addr;
        READ:    idx_q <= IDX_W'(FRAME_BYTES - 1);
        LATCH: begin
          frame_q <= pack_frame(addr_q, bus.imem_rd_data);
          cnt_q   <= CNT_W'(FIRST_WAIT);
        end
        SETUP:   if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        RELEASE: if (!ack_s && idx_q != '0) begin
          idx_q <= idx_q - IDX_W'(1);
          cnt_q <= CNT_W'(NEXT_WAIT);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = READ;
      READ:    nxt = LATCH;
      LATCH:   nxt = SETUP;
      // ack_s must be seen low before strobing so a stale ack from the
      // previous handshake cannot complete this one.
      SETUP:   if (cnt_q == '0 && !ack_s) nxt = STROBE;
      STROBE:  if (ack_s) nxt = RELEASE;
      RELEASE: if (!ack_s) nxt = (idx_q == '0) ? IDLE : SETUP;
      default: nxt = IDLE;
    endcase
    if (bus.abort && state != IDLE) nxt = IDLE;
  end

  // All outputs decode from the state flop so reset clears them at once.
  always_comb begin
    bus.out_byte = 8'h00;
    case (state)
      // read data arrives this cycle; present it straight away so the
      // first byte gets its full setup time
      LATCH:                  bus.out_byte = frame_byte(pack_frame(addr_q, bus.imem_rd_data), idx_q);
      SETUP, STROBE, RELEASE: bus.out_byte = frame_byte(frame_q, idx_q);
      default:                bus.out_byte = 8'h00;
    endcase
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.imem_rd_en  = (state == READ);
  assign bus.imem_rd_adr = (state == READ) ? addr_q : '0;
  assign bus.out_strobe  = (state == STROBE);
  assign bus.done        = (state == RELEASE) && !ack_s && (idx_q == '0) && !bus.abort;

endmodule

// File: tb/tb_imem_readback_tx.sv
// Directed bench for imem_readback_tx: reset values, single-frame timing,
// stale ack, abort, async reset mid-strobe and back-to-back requests.
module tb_imem_readback_tx;
  import pat_link_pkg::*;

  logic clk_int = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_int = ~clk_int;

  imem_readback_tx_if bus ();

  imem_readback_tx #(.SETUP_CYCLES(2)) dut (
    .clk_int (clk_int),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    case (a)
      10'h2A5: return 40'h12_3456_789A;
      10'h3FF: return 40'hFF_EEDD_CCBB;
      10'h000: return 40'hCA_FEBA_BE01;
      default: return '0;
    endcase
  endfunction

  // iMem model: registered read, data valid the cycle after rd_en
  always @(posedge clk_int)
    if (bus.imem_rd_en) bus.imem_rd_data <= mem_word(bus.imem_rd_adr);

  int   rd_cnt = 0, done_cnt = 0, str_cnt = 0;
  logic str_d = 1'b0;
  always @(posedge clk_int) begin
    if (bus.imem_rd_en) rd_cnt <= rd_cnt + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.out_strobe && !str_d) str_cnt <= str_cnt + 1;
    str_d <= bus.out_strobe;
  end

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_int);
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    while (bus.out_strobe !== 1'b1 && n < 60) begin tick(); n++; end
    chk({tag, "_strobe"}, bus.out_strobe, 1);
  endtask

  // host side of one byte: ack 3 cycles after strobe, drop ack once strobe falls
  task automatic host_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    wait_strobe(tag);
    chk({tag, "_byte"}, bus.out_byte, exp);
    repeat (3) tick();
    chk({tag, "_hold"}, bus.out_byte, exp);
    bus.host_ack = 1'b1;
    while (bus.out_strobe !== 1'b0 && n < 60) begin tick(); n++; end
    chk({tag, "_release"}, bus.out_strobe, 0);
    bus.host_ack = 1'b0;
  endtask

  task automatic send_frame(input string tag, input logic [55:0] frame);
    for (int i = 6; i >= 0; i--)
      host_byte($sformatf("%s_b%0d", tag, i), frame[i*8 +: 8]);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < 60) begin tick(); n++; end
    chk({tag, "_done"}, bus.done, 1);
  endtask

  task automatic request(input logic [ADDR_W-1:0] a);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int r0, d0, s0;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.abort     = 1'b0;
    bus.host_ack  = 1'b0;
    reset_n       = 1'b0;
    repeat (2) tick();
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_strobe", bus.out_strobe, 0);
    chk("rst_byte", bus.out_byte, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rden", bus.imem_rd_en, 0);
    reset_n = 1'b1;
    tick();

    // single frame with latency check (accept at T)
    r0 = rd_cnt; d0 = done_cnt; s0 = str_cnt;
    bus.req_valid = 1'b1;
    bus.req_addr  = 10'h2A5;
    tick();                                   // T+1
    chk("t1_rden", bus.imem_rd_en, 1);
    chk("t1_adr", bus.imem_rd_adr, 10'h2A5);
    chk("t1_ready", bus.req_ready, 0);
    bus.req_valid = 1'b0;
    tick();                                   // T+2
    chk("t2_rden", bus.imem_rd_en, 0);
    chk("t2_byte", bus.out_byte, 8'h02);
    chk("t2_strobe", bus.out_strobe, 0);
    tick();                                   // T+3
    chk("t3_byte", bus.out_byte, 8'h02);
    chk("t3_strobe", bus.out_strobe, 0);
    tick();                                   // T+4
    chk("t4_strobe", bus.out_strobe, 1);
    send_frame("f1", 56'h02A5_1234_5678_9A);
    wait_done("f1");
    tick();
    chk("f1_ready", bus.req_ready, 1);
    chk("f1_ndone", done_cnt - d0, 1);
    chk("f1_nrd", rd_cnt - r0, 1);
    chk("f1_nstr", str_cnt - s0, 7);

    // stale ack: host_ack high before the request
    s0 = str_cnt;
    bus.host_ack = 1'b1;
    repeat (3) tick();
    request(10'h3FF);
    repeat (10) tick();
    chk("stale_nostr", str_cnt - s0, 0);
    chk("stale_busy", bus.busy, 1);
    chk("stale_byte", bus.out_byte, 8'h03);
    bus.host_ack = 1'b0;
    send_frame("f2", 56'h03FF_FFEE_DDCC_BB);
    wait_done("f2");
    tick();
    chk("f2_nstr", str_cnt - s0, 7);

    // abort during byte 3 (0x34) while strobe is high
    d0 = done_cnt;
    request(10'h2A5);
    host_byte("ab_b6", 8'h02);
    host_byte("ab_b5", 8'hA5);
    host_byte("ab_b4", 8'h12);
    wait_strobe("ab_b3");
    chk("ab_b3_byte", bus.out_byte, 8'h34);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_strobe", bus.out_strobe, 0);
    chk("ab_byte", bus.out_byte, 0);
    chk("ab_busy", bus.busy, 0);
    repeat (3) tick();
    chk("ab_nodone", done_cnt - d0, 0);
    // abort together with req_valid in IDLE blocks the accept
    bus.req_valid = 1'b1;
    bus.req_addr  = 10'h000;
    bus.abort     = 1'b1;
    tick();
    chk("abv_busy", bus.busy, 0);
    bus.abort = 1'b0;
    tick();
    chk("abv_accept", bus.busy, 1);
    bus.req_valid = 1'b0;
    send_frame("f3", 56'h0000_CAFE_BABE_01);
    wait_done("f3");
    tick();
    chk("f3_ndone", done_cnt - d0, 1);

    // async reset while in STROBE
    request(10'h2A5);
    wait_strobe("rs");
    #2 reset_n = 1'b0;
    #1;
    chk("rs_strobe", bus.out_strobe, 0);
    chk("rs_busy", bus.busy, 0);
    chk("rs_done", bus.done, 0);
    chk("rs_byte", bus.out_byte, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rs_ready", bus.req_ready, 1);

    // back-to-back: second request held through the first frame
    r0 = rd_cnt; d0 = done_cnt; s0 = str_cnt;
    bus.req_valid = 1'b1;
    bus.req_addr  = 10'h2A5;
    tick();
    chk("bb_busy", bus.busy, 1);
    bus.req_addr = 10'h3FF;
    send_frame("bb1", 56'h02A5_1234_5678_9A);
    wait_done("bb1");
    chk("bb_ready_at_done", bus.req_ready, 0);
    tick();
    chk("bb_ready_after", bus.req_ready, 1);
    tick();
    chk("bb_rden2", bus.imem_rd_en, 1);
    chk("bb_adr2", bus.imem_rd_adr, 10'h3FF);
    bus.req_valid = 1'b0;
    send_frame("bb2", 56'h03FF_FFEE_DDCC_BB);
    wait_done("bb2");
    tick();
    chk("bb_nrd", rd_cnt - r0, 2);
    chk("bb_nstr", str_cnt - s0, 14);
    chk("bb_ndone", done_cnt - d0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
